muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  in  1  operation request, sampled only in IDLE.
REQ-005 SHALL have port op  in  1  0 = MULTU, 1 = DIVU (unsigned).
REQ-006 SHALL have port rs_val  in  32  multiplicand / dividend.
REQ-007 SHALL have port rt_val  in  32  multiplier / divisor.
REQ-008 SHALL have port busy  out  1  high while an operation is in flight, including the DONE cycle.
REQ-009 SHALL have port done  out  1  one-cycle pulse; hi/lo valid from this cycle on.
REQ-010 SHALL have port hi  out  32  HI register: product upper word / remainder.
REQ-011 SHALL have port lo  out  32  LO register: product lower word / quotient.
REQ-012 SHALL have port alu_in1  out  32  operand A driven to the shared ALU_Unit.
REQ-013 SHALL have port alu_in2  out  32  operand B driven to the shared ALU_Unit.
REQ-014 SHALL have port alu_sel  out  4  ALU_Unit selection code.
REQ-015 SHALL have port alu_result  in  32  combinational result returned by ALU_Unit.

Function
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, DONE; the accumulator, iteration counter and FSM state are registered.
REQ-017 IDLE with start=1 SHALL latch rt_val and set count=0; op=0 -> MUL with HI=0, LO=rs_val; op=1 with rt_val!=0 -> DIV with HI=0, LO=rs_val.
REQ-018 DIVU with rt_val=0 SHALL go IDLE -> DONE directly, setting HI=rs_val, LO=32'hFFFFFFFF.
REQ-019 In MUL, each cycle SHALL drive alu_sel=ADD (4'b0010), alu_in1=HI, alu_in2=multiplicand; if LO[0]=1, {HI,LO} <= {carry, alu_result, LO[31:1]} with carry = (alu_result < HI unsigned), else {HI,LO} <= {1'b0, HI, LO[31:1]}.
REQ-020 In DIV, each cycle SHALL form {b, R} = {HI, LO[31]} (b = HI[31], R = 32-bit shifted remainder), drive alu_sel=SUB (4'b0110), alu_in1=R, alu_in2=divisor; if b=1 or R>=divisor (unsigned): HI<=alu_result, LO<={LO[30:0],1}; else HI<=R, LO<={LO[30:0],0}.
REQ-021 MUL and DIV SHALL each run exactly 32 iterations (count 0..31), then go to DONE.
REQ-022 Latency: start sampled at edge k SHALL give done=1 in cycle k+33 (MUL/DIV), k+1 (divide by zero).
REQ-023 DONE SHALL last one cycle with done=1, busy=1, then return to IDLE; hi/lo SHALL hold until the next accepted start.
REQ-024 start SHALL be ignored while busy=1; op/rs_val/rt_val changes after acceptance SHALL not affect the result.
REQ-025 In IDLE and DONE the block SHALL drive alu_sel=ADD, alu_in1=0, alu_in2=0.
REQ-026 busy SHALL be high in MUL, DIV, DONE; low in IDLE.

Reset
REQ-027 Reset assertion SHALL immediately force state=IDLE, busy=0, done=0, hi=0, lo=0, count=0, operand latches=0, at any time including mid-operation; no partial result is retained.
REQ-028 The first start SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-029 A shared package muldiv_pkg SHALL hold the FSM state enum, ALU_ADD=4'b0010, ALU_SUB=4'b0110, and MULDIV_ITER=32.
REQ-030 The block SHALL contain no sub-modules; ALU_Unit is instantiated alongside it by the enclosing datapath and by the bench.

Verification (bench wires ALU_Unit to alu_* ports)
REQ-031 MULTU 7 x 6 -> done at k+33, hi=0, lo=42.
REQ-032 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (carry path).
REQ-033 DIVU 100 / 7 -> lo=14, hi=2; DIVU 32'h80000000 / 3 -> lo=32'h2AAAAAAA, hi=2.
REQ-034 DIVU 5 / 0 -> done at k+1, hi=5, lo=32'hFFFFFFFF.
REQ-035 reset asserted during MUL iteration 10 -> same cycle busy=0, hi=0, lo=0; next start completes normally.
REQ-036 start pulsed with new operands during MUL -> ignored; result matches first operands, exactly one done pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential MULTU/DIVU engine: FSM states,
// ALU selection codes and the iteration count.
`timescale 1ns/1ps
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam int         MULDIV_ITER = 32;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequential unsigned multiply (shift-add) and restoring divide that borrow an
// external ALU_Unit for the per-iteration add/subtract.
`timescale 1ns/1ps
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result
);

  localparam int CNT_W = $clog2(MULDIV_ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULDIV_ITER - 1);

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_hi, r_lo, r_operand;
  logic [DATA_W-1:0] w_hi_nxt, w_lo_nxt, w_operand_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic [DATA_W-1:0] w_rem;
  logic              w_carry;
  logic              w_sub_ok;

  // Remainder shifted left by one; its lost top bit (r_hi MSB) forces a subtract.
  assign w_rem    = {r_hi[DATA_W-2:0], r_lo[DATA_W-1]};
  assign w_carry  = (alu_result < r_hi);
  assign w_sub_ok = r_hi[DATA_W-1] || (w_rem >= r_operand);

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;

  // ALU drive depends only on registered state, keeping alu_result out of a loop.
  always_comb begin
    alu_sel = ALU_ADD;
    alu_in1 = '0;
    alu_in2 = '0;
    case (r_state)
      ST_MUL: begin
        alu_in1 = r_hi;
        alu_in2 = r_operand;
      end
      ST_DIV: begin
        alu_sel = ALU_SUB;
        alu_in1 = w_rem;
        alu_in2 = r_operand;
      end
      default: ;
    endcase
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_operand_nxt = r_operand;
    w_count_nxt   = r_count;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_operand_nxt = rt_val;
          w_count_nxt   = '0;
          w_hi_nxt      = '0;
          w_lo_nxt      = rs_val;
          if (!op) begin
            w_state_nxt = ST_MUL;
          end else if (rt_val != '0) begin
            w_state_nxt = ST_DIV;
          end else begin
            w_state_nxt = ST_DONE;
            w_hi_nxt    = rs_val;
            w_lo_nxt    = '1;
          end
        end
      end
      ST_MUL: begin
        if (r_lo[0]) begin
          {w_hi_nxt, w_lo_nxt} = {w_carry, alu_result, r_lo[DATA_W-1:1]};
        end else begin
          {w_hi_nxt, w_lo_nxt} = {1'b0, r_hi, r_lo[DATA_W-1:1]};
        end
        w_count_nxt = r_count + 1'b1;
        if (r_count == LAST_ITER) w_state_nxt = ST_DONE;
      end
      ST_DIV: begin
        if (w_sub_ok) begin
          w_hi_nxt = alu_result;
          w_lo_nxt = {r_lo[DATA_W-2:0], 1'b1};
        end else begin
          w_hi_nxt = w_rem;
          w_lo_nxt = {r_lo[DATA_W-2:0], 1'b0};
        end
        w_count_nxt = r_count + 1'b1;
        if (r_count == LAST_ITER) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_operand <= '0;
      r_count   <= '0;
    end else begin
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_operand <= w_operand_nxt;
      r_count   <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench: randomized and directed MULTU/DIVU against an arithmetic model,
// with a behavioural ALU wired to the alu_* ports.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        busy, done;
  logic [31:0] hi, lo, alu_in1, alu_in2, alu_result;
  logic [3:0]  alu_sel;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_sel == SEL_ADD) ? alu_in1 + alu_in2 :
                      (alu_sel == SEL_SUB) ? alu_in1 - alu_in2 : 32'h0;

  muldiv_sequencer #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_sel(alu_sel), .alu_result(alu_result)
  );

  function automatic logic [63:0] model(input logic op_i, input logic [31:0] a, input logic [31:0] b);
    if (!op_i)       return 64'(a) * 64'(b);
    else if (b == 0) return {a, 32'hFFFF_FFFF};
    else             return {a % b, a / b};
  endfunction

  // Issues one operation and checks latency, result, handshake and the idle cycles after.
  task automatic run_op(input string name, input logic op_i, input logic [31:0] a,
                        input logic [31:0] b, input int inject_at);
    logic [63:0] exp;
    int cycles, exp_lat, done_cnt;
    bit busy_bad, alu_bad, hold_bad;
    exp      = model(op_i, a, b);
    exp_lat  = (op_i && b == 0) ? 0 : 32;
    busy_bad = 0; alu_bad = 0; hold_bad = 0; done_cnt = 0; cycles = 0;
    @(negedge clk);
    start = 1'b1; op = op_i; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); rs_val = $urandom; rt_val = $urandom;
    while (!done && cycles < 40) begin
      if (!busy) busy_bad = 1;
      if (alu_sel !== (op_i ? SEL_SUB : SEL_ADD)) alu_bad = 1;
      if (cycles == inject_at) begin
        start = 1'b1; op = 1'($urandom); rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL %s timeout: no done after %0d cycles", name, cycles);
    end
    n_checks++;
    if (cycles != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got %0d required %0d", name, cycles, exp_lat);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_in_done: got %b required 1", name, busy);
    end
    n_checks++;
    if (hi !== exp[63:32]) begin
      n_fail++; $display("FAIL %s hi: got %h required %h", name, hi, exp[63:32]);
    end
    n_checks++;
    if (lo !== exp[31:0]) begin
      n_fail++; $display("FAIL %s lo: got %h required %h", name, lo, exp[31:0]);
    end
    n_checks++;
    if (alu_sel !== SEL_ADD || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
      n_fail++; $display("FAIL %s alu_done: got sel=%b in1=%h in2=%h required 0010/0/0",
                         name, alu_sel, alu_in1, alu_in2);
    end
    n_checks++;
    if (busy_bad || alu_bad) begin
      n_fail++; $display("FAIL %s in_flight: busy_low=%0d wrong_alu_sel=%0d required 0/0",
                         name, busy_bad, alu_bad);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy || hi !== exp[63:32] || lo !== exp[31:0]) hold_bad = 1;
    end
    n_checks++;
    if (done_cnt != 0 || hold_bad) begin
      n_fail++; $display("FAIL %s after_done: extra_done=%0d hold_or_busy_bad=%0d required 0/0",
                         name, done_cnt, hold_bad);
    end
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required 0/0/0/0",
                         busy, done, hi, lo);
    end
    n_checks++;
    if (alu_sel !== SEL_ADD || alu_in1 !== 32'h0 || alu_in2 !== 32'h0) begin
      n_fail++; $display("FAIL reset_alu: sel=%b in1=%h in2=%h required 0010/0/0",
                         alu_sel, alu_in1, alu_in2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_op("mul_7x6", 1'b0, 32'd7, 32'd6, -1);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, -1);
    run_op("div_msb_3", 1'b1, 32'h8000_0000, 32'd3, -1);
    run_op("div_by_zero", 1'b1, 32'd5, 32'd0, -1);
    run_op("div_max_1", 1'b1, 32'hFFFF_FFFF, 32'd1, -1);
    run_op("div_small_big", 1'b1, 32'd3, 32'hFFFF_FFFF, -1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        o;
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      run_op($sformatf("rand_%0d", i), o, a, b, -1);
    end
  endtask

  task automatic test_start_ignored();
    run_op("mul_ignore_start", 1'b0, $urandom, $urandom, 5);
    run_op("div_ignore_start", 1'b1, $urandom, 32'($urandom_range(1, 1000)), 20);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; op = 1'b0; rs_val = 32'hDEAD_BEEF; rt_val = 32'h1234_5679;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h required 0/0/0/0",
                         busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op("after_reset_mul", 1'b0, $urandom, $urandom, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
